// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter between icache fill and dcache access
// Data side has fixed priority; a starvation guard and an access watchdog bound latency.
module mem_arbiter #(
  parameter int          STARVE_LIMIT = 4,
  parameter int          TIMEOUT_CYC  = 64,
  parameter logic [31:0] ERR_WORD     = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic        timeout_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT_CYC - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;   // 1 = data side
  logic          op_q, op_d;         // 1 = write
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   store_q, store_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [WW-1:0] wd_q, wd_d;

  logic        d_req;
  logic        expired;
  logic [31:0] rd_word;

  assign d_req = dREN | dWEN;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      op_q     <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      starve_q <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      starve_q <= starve_d;
      wd_q     <= wd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    op_d        = op_q;
    addr_d      = addr_q;
    store_d     = store_q;
    starve_d    = starve_q;
    wd_d        = wd_q;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    iwait       = 1'b1;
    dwait       = 1'b1;
    iload       = '0;
    dload       = '0;
    timeout_err = 1'b0;
    expired     = 1'b0;
    rd_word     = '0;

    case (state_q)
      IDLE: begin
        // The guard only yields to a waiting fetch; a lone data request is never blocked.
        if (d_req && ((starve_q < STARVE_MAX) || !iREN)) begin
          owner_d  = 1'b1;
          op_d     = dWEN;
          addr_d   = daddr;
          store_d  = dstore;
          starve_d = iREN ? starve_q + 1'b1 : '0;
          wd_d     = '0;
          state_d  = ACCESS;
        end else if (iREN) begin
          owner_d  = 1'b0;
          op_d     = 1'b0;
          addr_d   = iaddr;
          store_d  = '0;
          starve_d = '0;
          wd_d     = '0;
          state_d  = ACCESS;
        end
      end

      ACCESS: begin
        ramREN   = !op_q;
        ramWEN   = op_q;
        ramaddr  = addr_q;
        ramstore = store_q;
        expired  = (wd_q == WD_LAST) && !ram_ready;
        if (ram_ready || expired) begin
          timeout_err = expired;
          if (!op_q) rd_word = expired ? ERR_WORD : ramload;
          if (owner_q) begin
            dwait = 1'b0;
            dload = rd_word;
          end else begin
            iwait = 1'b0;
            iload = rd_word;
          end
          wd_d    = '0;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
